// File: rtl/descrambler_sync_if.sv
// descrambler_sync_if: serial descrambler control, data and status bundle
interface descrambler_sync_if #(parameter int LEN_W = 16);
  logic             Start;
  logic [LEN_W-1:0] Len;
  logic             En;
  logic             Data;
  logic             Out;
  logic             Out_valid;
  logic             Locked;
  logic [6:0]       Lfsr_state;
  logic             Service_err;
  logic             Busy;
  logic             Done;
  modport master(output Start, Len, En, Data,
                 input Out, Out_valid, Locked, Lfsr_state, Service_err, Busy, Done);
  modport slave(input Start, Len, En, Data,
                output Out, Out_valid, Locked, Lfsr_state, Service_err, Busy, Done);
endinterface

// File: rtl/descrambler_sync.sv
// descrambler_sync: recovers the x^7+x^4+1 scrambler state from SERVICE and descrambles the payload
module descrambler_sync #(
  parameter int LFSR_LEN     = 7,
  parameter int SERVICE_BITS = 16,
  parameter int LEN_W        = 16
) (
  input logic          Clk,
  input logic          Reset,
  descrambler_sync_if.slave bus
);
  localparam int CW = $clog2(SERVICE_BITS);
  typedef enum logic [2:0] {IDLE, SYNC, SERVICE, DATA, DONE} state_t;
  state_t              state_q, state_d;
  logic [LFSR_LEN-1:0] s_q, s_d, lfsr_state_q, lfsr_state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                out_q, out_d, out_valid_q, out_valid_d;
  logic                locked_q, locked_d, err_q, err_d, done_q, done_d;
  logic                fb, ob, sync_last, svc_last;
  assign fb        = s_q[LFSR_LEN-1] ^ s_q[3];
  assign ob        = bus.Data ^ fb;
  assign sync_last = cnt_q == CW'(LFSR_LEN - 1);
  assign svc_last  = cnt_q == CW'(SERVICE_BITS - LFSR_LEN - 1);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      lfsr_state_q <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      lfsr_state_q <= lfsr_state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (bus.Start) state_d = SYNC;
    else
      case (state_q)
        SYNC:    if (bus.En && sync_last) state_d = SERVICE;
        SERVICE: if (bus.En && svc_last) state_d = (len_q == '0) ? DONE : DATA;
        DATA:    if (bus.En && len_q <= LEN_W'(1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
  end
  // Once synced the LFSR runs on its own feedback, so a corrupted input bit never poisons later bits.
  always_comb begin
    s_d          = s_q;
    lfsr_state_d = lfsr_state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    locked_d     = locked_q;
    err_d        = err_q;
    done_d       = 1'b0;
    if (bus.Start) begin
      s_d      = '0;
      cnt_d    = '0;
      len_d    = bus.Len;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else if (state_q == SYNC && bus.En) begin
      s_d   = {s_q[LFSR_LEN-2:0], bus.Data};
      cnt_d = sync_last ? '0 : cnt_q + 1'b1;
      if (sync_last) begin
        locked_d     = 1'b1;
        lfsr_state_d = {s_q[LFSR_LEN-2:0], bus.Data};
      end
    end else if (state_q == SERVICE && bus.En) begin
      s_d   = {s_q[LFSR_LEN-2:0], fb};
      cnt_d = cnt_q + 1'b1;
      err_d = err_q | ob;
    end else if (state_q == DATA && bus.En) begin
      s_d         = {s_q[LFSR_LEN-2:0], fb};
      out_d       = ob;
      out_valid_d = 1'b1;
      len_d       = (len_q == '0) ? '0 : len_q - 1'b1;
    end else if (state_q == DONE) begin
      locked_d = 1'b0;
      done_d   = 1'b1;
    end
  end
  assign bus.Out         = out_q;
  assign bus.Out_valid   = out_valid_q;
  assign bus.Locked      = locked_q;
  assign bus.Lfsr_state  = lfsr_state_q;
  assign bus.Service_err = err_q;
  assign bus.Busy        = state_q != IDLE;
  assign bus.Done        = done_q;
endmodule

// File: tb/tb_descrambler_sync.sv
// tb_descrambler_sync: transmit-scrambler model feeds random frames; received payload compared to plaintext
module tb_descrambler_sync;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int total = 0;
  int bad = 0;
  descrambler_sync_if #(.LEN_W(16)) bus ();
  descrambler_sync dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));
  always #5 Clk = ~Clk;
  logic pay_q[$];
  logic tx_q[$];
  logic rx[$];
  int n = 0;
  int first_valid, last_valid, done_cnt, done_cyc, vbad;
  task automatic clear_rec();
    rx.delete();
    first_valid = -1;
    last_valid = -1;
    done_cnt = 0;
    done_cyc = -1;
    vbad = 0;
  endtask
  // One clock: inputs applied after a falling edge, registered outputs logged at the next falling edge.
  task automatic cyc(input logic st, input logic en, input logic d);
    bus.Start = st;
    bus.En = en;
    bus.Data = d;
    @(negedge Clk);
    n++;
    if (bus.Out_valid) begin
      rx.push_back(bus.Out);
      if (first_valid < 0) first_valid = n;
      last_valid = n;
      if (!en || bus.Done) vbad++;
    end
    if (bus.Done) begin
      done_cnt++;
      done_cyc = n;
    end
  endtask
  task automatic start(input int len);
    bus.Len = 16'(len);
    cyc(1'b1, 1'($urandom), 1'($urandom));
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'($urandom));
  endtask
  // Transmitter: 16 zero SERVICE bits then the payload, scrambled from the given seed.
  task automatic make_frame(input logic [6:0] seed, input int len, input bit zero, input int flip);
    logic [6:0] s;
    logic p, f;
    pay_q.delete();
    tx_q.delete();
    s = seed;
    for (int i = 0; i < 16 + len; i++) begin
      p = (i < 16 || zero) ? 1'b0 : 1'($urandom);
      if (i >= 16) pay_q.push_back(p);
      f = s[6] ^ s[3];
      tx_q.push_back(p ^ f ^ (i == flip));
      s = {s[5:0], f};
    end
  endtask
  function automatic int qdiff(input logic a[$], input logic b[$]);
    int c = (a.size() == b.size()) ? 0 : 1;
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) c++;
    return c;
  endfunction
  task automatic test_reset();
    logic [12:0] o;
    Reset = 1'b1;
    bus.Len = '0;
    idle(2);
    Reset = 1'b0;
    o = {bus.Out, bus.Out_valid, bus.Locked, bus.Lfsr_state, bus.Service_err, bus.Busy, bus.Done};
    total++;
    if (o !== 13'h0) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
  endtask
  task automatic test_zero_payload();
    logic z[$];
    make_frame(7'h7F, 16, 1'b1, -1);
    clear_rec();
    start(16);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, tx_q[i]);
      if (i == 6) begin
        total++;
        if (bus.Lfsr_state !== 7'h07) begin bad++; $display("FAIL zero_lfsr_state got=%h want=07", bus.Lfsr_state); end
        total++;
        if (bus.Locked !== 1'b1) begin bad++; $display("FAIL zero_locked got=%b want=1", bus.Locked); end
      end
    end
    idle(3);
    for (int i = 0; i < 16; i++) z.push_back(1'b0);
    total++;
    if (bus.Service_err !== 1'b0) begin bad++; $display("FAIL zero_service_err got=%b want=0", bus.Service_err); end
    total++;
    if (qdiff(rx, z) != 0) begin bad++; $display("FAIL zero_payload got_len=%0d want_len=16 diffs=%0d", rx.size(), qdiff(rx, z)); end
    total++;
    if (done_cnt != 1 || done_cyc != last_valid + 1 || vbad != 0)
      begin bad++; $display("FAIL zero_done got cnt=%0d cyc=%0d vbad=%0d want cnt=1 cyc=%0d vbad=0", done_cnt, done_cyc, vbad, last_valid + 1); end
    total++;
    if (bus.Locked !== 1'b0 || bus.Busy !== 1'b0) begin bad++; $display("FAIL zero_idle got locked=%b busy=%b want 0 0", bus.Locked, bus.Busy); end
  endtask
  task automatic test_random_payload(input int flip);
    int first_data;
    make_frame(7'b1011101, 200, 1'b0, flip);
    clear_rec();
    start(200);
    first_data = -1;
    for (int i = 0; i < 216; i++) begin
      cyc(1'b0, 1'b1, tx_q[i]);
      if (i == 16) first_data = n;
    end
    idle(3);
    total++;
    if (qdiff(rx, pay_q) != 0) begin bad++; $display("FAIL rand_payload flip=%0d got_len=%0d want_len=200 diffs=%0d", flip, rx.size(), qdiff(rx, pay_q)); end
    total++;
    if (first_valid != first_data) begin bad++; $display("FAIL rand_latency got=%0d want=%0d", first_valid, first_data); end
    total++;
    if (bus.Service_err !== (flip >= 0)) begin bad++; $display("FAIL rand_service_err flip=%0d got=%b want=%b", flip, bus.Service_err, flip >= 0); end
    total++;
    if (done_cnt != 1 || done_cyc != last_valid + 1) begin bad++; $display("FAIL rand_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, last_valid + 1); end
  endtask
  task automatic test_service_err();
    test_random_payload(10);
    idle(5);
    total++;
    if (bus.Service_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.Service_err); end
    start(4);
    total++;
    if (bus.Service_err !== 1'b0) begin bad++; $display("FAIL err_clear_on_start got=%b want=0", bus.Service_err); end
  endtask
  task automatic test_en_toggle();
    make_frame(7'($urandom_range(1, 127)), 8, 1'b0, -1);
    clear_rec();
    start(8);
    foreach (tx_q[i]) begin
      cyc(1'b0, 1'b1, tx_q[i]);
      cyc(1'b0, 1'b0, 1'($urandom));
    end
    idle(3);
    total++;
    if (qdiff(rx, pay_q) != 0) begin bad++; $display("FAIL toggle_payload got_len=%0d want_len=8 diffs=%0d", rx.size(), qdiff(rx, pay_q)); end
    total++;
    if (vbad != 0) begin bad++; $display("FAIL toggle_valid_after_idle got=%0d want=0", vbad); end
    total++;
    if (done_cnt != 1 || done_cyc <= last_valid) begin bad++; $display("FAIL toggle_done got cnt=%0d cyc=%0d last_valid=%0d want cnt=1 after", done_cnt, done_cyc, last_valid); end
  endtask
  task automatic test_abort();
    logic exp[$];
    make_frame(7'($urandom_range(1, 127)), 50, 1'b0, -1);
    for (int i = 0; i < 5; i++) exp.push_back(pay_q[i]);
    clear_rec();
    start(50);
    for (int i = 0; i < 21; i++) cyc(1'b0, 1'b1, tx_q[i]);
    total++;
    if (bus.Locked !== 1'b1) begin bad++; $display("FAIL abort_locked_before got=%b want=1", bus.Locked); end
    make_frame(7'($urandom_range(1, 127)), 4, 1'b0, -1);
    foreach (pay_q[i]) exp.push_back(pay_q[i]);
    bus.Len = 16'd4;
    cyc(1'b1, 1'b1, 1'($urandom));
    total++;
    if (bus.Locked !== 1'b0 || bus.Busy !== 1'b1) begin bad++; $display("FAIL abort_restart got locked=%b busy=%b want 0 1", bus.Locked, bus.Busy); end
    foreach (tx_q[i]) cyc(1'b0, 1'b1, tx_q[i]);
    idle(3);
    total++;
    if (qdiff(rx, exp) != 0) begin bad++; $display("FAIL abort_payload got_len=%0d want_len=9 diffs=%0d", rx.size(), qdiff(rx, exp)); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL abort_done_count got=%0d want=1", done_cnt); end
  endtask
  task automatic test_reset_len0();
    logic [12:0] o;
    int last_svc;
    make_frame(7'($urandom_range(1, 127)), 20, 1'b0, -1);
    start(20);
    for (int i = 0; i < 19; i++) cyc(1'b0, 1'b1, tx_q[i]);
    Reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    Reset = 1'b0;
    o = {bus.Out, bus.Out_valid, bus.Locked, bus.Lfsr_state, bus.Service_err, bus.Busy, bus.Done};
    total++;
    if (o !== 13'h0) begin bad++; $display("FAIL midframe_reset got=%h want=0", o); end
    make_frame(7'($urandom_range(1, 127)), 0, 1'b0, -1);
    clear_rec();
    start(0);
    last_svc = -1;
    foreach (tx_q[i]) begin
      cyc(1'b0, 1'b1, tx_q[i]);
      last_svc = n;
    end
    idle(3);
    total++;
    if (rx.size() != 0) begin bad++; $display("FAIL len0_no_valid got=%0d want=0", rx.size()); end
    total++;
    if (done_cnt != 1 || done_cyc != last_svc + 1) begin bad++; $display("FAIL len0_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, last_svc + 1); end
    total++;
    if (bus.Busy !== 1'b0 || bus.Service_err !== 1'b0) begin bad++; $display("FAIL len0_idle got busy=%b err=%b want 0 0", bus.Busy, bus.Service_err); end
  endtask
  initial begin
    bus.Start = 1'b0;
    bus.En = 1'b0;
    bus.Data = 1'b0;
    bus.Len = '0;
    clear_rec();
    test_reset();
    test_zero_payload();
    test_random_payload(-1);
    test_service_err();
    test_en_toggle();
    test_abort();
    test_reset_len0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
